// File: rtl/ram_program_loader_if.sv
// Host-link/RAM-write bundle between the program loader and its neighbours.
// Latency: none, wires only.
// Backpressure: oByteReady throttles the iByteValid/iByte stream.
interface ram_program_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  iStart;
  logic                  iAbort;
  logic [ADDR_WIDTH-1:0] iBaseAddress;
  logic [ADDR_WIDTH:0]   iWordCount;
  logic                  iByteValid;
  logic [BYTE_WIDTH-1:0] iByte;
  logic                  oByteReady;
  logic                  oWriteEnable;
  logic [ADDR_WIDTH-1:0] oWriteAddress;
  logic [DATA_WIDTH-1:0] oWriteData;
  logic                  oBusy;
  logic                  oCpuReset;
  logic                  oDone;
  logic                  oError;
  logic [ADDR_WIDTH:0]   oWordsWritten;

  // Host side: issues commands and bytes, observes the loader.
  modport master (
    output iStart, iAbort, iBaseAddress, iWordCount, iByteValid, iByte,
    input  oByteReady, oWriteEnable, oWriteAddress, oWriteData,
           oBusy, oCpuReset, oDone, oError, oWordsWritten
  );

  // Loader side.
  modport slave (
    input  iStart, iAbort, iBaseAddress, iWordCount, iByteValid, iByte,
    output oByteReady, oWriteEnable, oWriteAddress, oWriteData,
           oBusy, oCpuReset, oDone, oError, oWordsWritten
  );
endinterface

// File: rtl/ram_program_loader.sv
// Packs a byte stream into RAM words and writes them at consecutive addresses, holding the CPU in reset.
// Latency: last byte of a word accepted at edge N -> write enable high from N to N+1.
// Backpressure: oByteReady is low outside COLLECT, so one idle byte slot per word (BPW+1 cycles/word).
module ram_program_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 1023
) (
  input logic                   Clock,
  input logic                   Reset,
  ram_program_loader_if.slave   bus
);
  localparam int BPW  = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDXW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic [IDXW-1:0]       idx;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] next_word;

  // Word with the current stream byte shifted in at the least-significant end.
  always_comb begin
    next_word = (word << BYTE_WIDTH) | DATA_WIDTH'(bus.iByte);
  end

  // CPU stays in reset for exactly as long as a load is running.
  assign bus.oCpuReset = bus.oBusy;

  // Load sequencer; every output is registered alongside the state it belongs to.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state             <= IDLE;
      addr              <= '0;
      remaining         <= '0;
      idx               <= '0;
      word              <= '0;
      bus.oByteReady    <= 1'b0;
      bus.oWriteEnable  <= 1'b0;
      bus.oWriteAddress <= '0;
      bus.oWriteData    <= '0;
      bus.oBusy         <= 1'b0;
      bus.oDone         <= 1'b0;
      bus.oError        <= 1'b0;
      bus.oWordsWritten <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (bus.iStart) begin
            addr              <= bus.iBaseAddress;
            remaining         <= bus.iWordCount;
            idx               <= '0;
            word              <= '0;
            bus.oDone         <= 1'b0;
            bus.oError        <= 1'b0;
            bus.oWordsWritten <= '0;
            if (bus.iWordCount == '0) begin
              state     <= DONE;
              bus.oDone <= 1'b1;
            end else if ({1'b0, bus.iBaseAddress} > (ADDR_WIDTH+1)'(MEM_SIZE)) begin
              state      <= ERROR;
              bus.oError <= 1'b1;
            end else begin
              state          <= COLLECT;
              bus.oByteReady <= 1'b1;
              bus.oBusy      <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (bus.iAbort) begin
            // Partial word is simply forgotten; idx restarts for the next load.
            state          <= IDLE;
            idx            <= '0;
            bus.oByteReady <= 1'b0;
            bus.oBusy      <= 1'b0;
          end else if (bus.iByteValid) begin
            word <= next_word;
            if (idx == IDXW'(BPW - 1)) begin
              idx               <= '0;
              state             <= WRITE;
              bus.oByteReady    <= 1'b0;
              bus.oWriteEnable  <= 1'b1;
              bus.oWriteAddress <= addr;
              bus.oWriteData    <= next_word;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        WRITE: begin
          // The RAM captures the presented word at this edge, even on abort.
          bus.oWriteEnable  <= 1'b0;
          bus.oWordsWritten <= bus.oWordsWritten + (ADDR_WIDTH+1)'(1);
          if (bus.iAbort) begin
            state     <= IDLE;
            bus.oBusy <= 1'b0;
          end else if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state     <= DONE;
            bus.oDone <= 1'b1;
            bus.oBusy <= 1'b0;
          end else if (addr == ADDR_WIDTH'(MEM_SIZE)) begin
            // Top of RAM reached with words still owed: stop rather than wrap.
            state      <= ERROR;
            bus.oError <= 1'b1;
            bus.oBusy  <= 1'b0;
          end else begin
            state          <= COLLECT;
            addr           <= addr + ADDR_WIDTH'(1);
            remaining      <= remaining - (ADDR_WIDTH+1)'(1);
            bus.oByteReady <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ram_program_loader.sv
// Bench for ram_program_loader: directed scenarios plus random loads against a word-list model.
// Latency: checks writes as they appear on the RAM port via a scoreboard queue.
// Backpressure: byte feeder honours oByteReady and optionally inserts random valid gaps.
module tb_ram_program_loader;
  localparam int DW = 16;
  localparam int BW = 8;
  localparam int AW = 10;
  localparam int MS = 1023;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;
  wr_t  exp_q[$];
  logic [7:0] stim_q[$];

  ram_program_loader_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  ram_program_loader #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .MEM_SIZE(MS)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write must match the oldest outstanding expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge Clock);
      if (!Reset && bus.oWriteEnable === 1'b1) begin
        chk("ready_low_in_write", 32'(bus.oByteReady), 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%0h@%0h required=none", bus.oWriteData, bus.oWriteAddress);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(bus.oWriteAddress), e.addr);
          chk("write_data", 32'(bus.oWriteData), e.data);
        end
      end
    end
  end

  // All tasks start and end at posedge+1.
  task automatic do_start(input int base, input int count);
    bus.iStart       = 1'b1;
    bus.iBaseAddress = AW'(base);
    bus.iWordCount   = (AW+1)'(count);
    @(posedge Clock); #1;
    bus.iStart = 1'b0;
  endtask

  task automatic feed(input int first, input int n, input bit gaps);
    int i = 0;
    int cyc = 0;
    logic rdy;
    logic v;
    while (i < n && cyc < 400) begin
      rdy = bus.oByteReady;
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.iByteValid = v;
      bus.iByte      = stim_q[first + i];
      @(posedge Clock); #1;
      if (v && rdy) i++;
      cyc++;
    end
    bus.iByteValid = 1'b0;
    chk("bytes_accepted", 32'(i), 32'(n));
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (bus.oBusy !== 1'b0 && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    chk("idle_timeout", 32'(bus.oBusy), 0);
    @(posedge Clock); #1;
  endtask

  // Model: words are consecutive MSB-first byte pairs; writes stop after address MS.
  task automatic run_load(input int base, input int count, input bit gaps);
    int n;
    wr_t e;
    n = (count < MS + 1 - base) ? count : MS + 1 - base;
    for (int w = 0; w < n; w++) begin
      e.addr = base + w;
      e.data = {stim_q[2*w], stim_q[2*w+1]};
      exp_q.push_back(e);
    end
    do_start(base, count);
    if (count > 0) chk("cpu_reset_during_load", 32'(bus.oCpuReset), 1);
    feed(0, 2 * n, gaps);
    wait_idle();
    chk("done", 32'(bus.oDone), (count == n) ? 1 : 0);
    chk("error", 32'(bus.oError), (count != n) ? 1 : 0);
    chk("words_written", 32'(bus.oWordsWritten), 32'(n));
    chk("cpu_reset_after", 32'(bus.oCpuReset), 0);
    chk("pending_writes", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_flags"}, 32'({bus.oByteReady, bus.oWriteEnable, bus.oBusy,
                               bus.oCpuReset, bus.oDone, bus.oError}), 0);
    chk({name, "_waddr"}, 32'(bus.oWriteAddress), 0);
    chk({name, "_wdata"}, 32'(bus.oWriteData), 0);
    chk({name, "_words"}, 32'(bus.oWordsWritten), 0);
  endtask

  initial begin
    int acc;
    int base;
    int count;
    wr_t e;
    total = 0;
    bad   = 0;
    bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iBaseAddress = '0;
    bus.iWordCount = '0; bus.iByteValid = 1'b0; bus.iByte = '0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_all_zero("reset");

    // Back-to-back bytes.
    stim_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(32'h010, 2, 1'b0);

    // Same load with valid gaps.
    run_load(32'h010, 2, 1'b1);

    // Zero-length load completes immediately.
    run_load(32'h100, 0, 1'b0);

    // Runs off the top of RAM after one word.
    stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(32'h3FF, 2, 1'b0);
    acc = 0;
    bus.iByteValid = 1'b1;
    bus.iByte = 8'hCC;
    repeat (3) begin
      if (bus.oByteReady) acc++;
      @(posedge Clock); #1;
    end
    bus.iByteValid = 1'b0;
    chk("no_accept_in_error", 32'(acc), 0);

    // Abort mid-word, then a fresh load must not see the stale byte.
    stim_q = '{8'h12};
    do_start(32'h030, 2);
    feed(0, 1, 1'b0);
    bus.iAbort = 1'b1;
    @(posedge Clock); #1;
    bus.iAbort = 1'b0;
    chk("abort_busy", 32'(bus.oBusy), 0);
    chk("abort_done_error", 32'({bus.oDone, bus.oError}), 0);
    stim_q = '{8'h9A, 8'hBC};
    run_load(32'h020, 1, 1'b0);

    // iStart ignored mid-load, then asynchronous reset mid-COLLECT.
    stim_q = '{8'h11, 8'h22, 8'h33};
    e.addr = 32'h040;
    e.data = 32'h1122;
    exp_q.push_back(e);
    do_start(32'h040, 3);
    feed(0, 1, 1'b0);
    do_start(32'h100, 1);
    feed(1, 1, 1'b0);
    repeat (2) begin @(posedge Clock); #1; end
    chk("midload_words", 32'(bus.oWordsWritten), 1);
    chk("midload_busy", 32'(bus.oBusy), 1);
    feed(2, 1, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge Clock); #1;
    Reset = 1'b0;
    repeat (3) begin @(posedge Clock); #1; end
    chk("reset_pending_writes", 32'(exp_q.size()), 0);

    // Random loads, some near the top of RAM.
    for (int t = 0; t < 10; t++) begin
      base  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1000) : $urandom_range(MS - 4, MS);
      count = $urandom_range(0, 6);
      stim_q.delete();
      for (int b = 0; b < 2 * count; b++) stim_q.push_back(8'($urandom));
      run_load(base, count, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
